// File: rtl/float_mul_issue_queue_pkg.sv
// Shared types for the multiplier issue queue: operand width, issue FSM states
// and the packed operation record carried through the FIFO.
package float_mul_issue_queue_pkg;

   localparam int unsigned float_width   = 32;
   localparam int unsigned mul_tag_width = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } mul_issue_state_e;

   typedef struct packed {
      logic [float_width-1:0]   a;
      logic [float_width-1:0]   b;
      logic [mul_tag_width-1:0] tag;
   } mul_op_t;

endpackage

// File: rtl/float_mul_issue_queue_sync_fifo.sv
// Power-of-two synchronous FIFO with occupancy count; the head entry is
// always visible on data_o, and pushes to a full / pops from an empty FIFO are ignored.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wrPtr_q, rdPtr_q;
   logic [PW:0]      count_q, count_d;
   logic             pushEn, popEn;

   assign pushEn  = push_i && (count_q != (PW+1)'(DEPTH));
   assign popEn   = pop_i && (count_q != '0);
   assign data_o  = mem_q[rdPtr_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (pushEn) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({pushEn, popEn})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (pushEn) wrPtr_q <= wrPtr_q + 1'b1;
         if (popEn)  rdPtr_q <= rdPtr_q + 1'b1;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/float_mul_issue_queue.sv
// Buffers tagged multiply operations, issues them one at a time to the
// multiplier over req/ack, and holds each product with its tag for the consumer.
module float_mul_issue_queue
   import float_mul_issue_queue_pkg::*;
#(
   parameter int unsigned FLOAT_WIDTH = float_width,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned TAG_WIDTH   = mul_tag_width,
   parameter int unsigned TIMEOUT     = 127
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [FLOAT_WIDTH-1:0]     in_a,
   input  logic [FLOAT_WIDTH-1:0]     in_b,
   input  logic [TAG_WIDTH-1:0]       in_tag,
   output logic                       mul_req,
   output logic [FLOAT_WIDTH-1:0]     mul_a,
   output logic [FLOAT_WIDTH-1:0]     mul_b,
   input  logic                       mul_ack,
   input  logic [FLOAT_WIDTH-1:0]     mul_out,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [FLOAT_WIDTH-1:0]     res_out,
   output logic [TAG_WIDTH-1:0]       res_tag,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       err
);

   localparam int unsigned OPW = 2*FLOAT_WIDTH + TAG_WIDTH;
   localparam int unsigned CW  = $clog2(DEPTH) + 1;
   localparam int unsigned WDW = $clog2(TIMEOUT + 1);

   mul_issue_state_e       state_q, state_d;
   logic [FLOAT_WIDTH-1:0] mulA_q, mulA_d, mulB_q, mulB_d;
   logic [FLOAT_WIDTH-1:0] resOut_q, resOut_d;
   logic [TAG_WIDTH-1:0]   tag_q, tag_d, resTag_q, resTag_d;
   logic                   resValid_q, resValid_d, err_q, err_d;
   logic [WDW-1:0]         wdog_q, wdog_d;
   logic [CW-1:0]          fifoCount;
   logic [OPW-1:0]         headOp;
   logic                   resFree, issue;

   assign in_ready = fifoCount < CW'(DEPTH);
   assign resFree  = !resValid_q || res_ready;
   assign issue    = (state_q == IDLE) && (fifoCount != '0) && resFree;

   sync_fifo #(
      .WIDTH (OPW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (rst),
      .push_i  (in_valid && in_ready),
      .pop_i   (issue),
      .data_i  ({in_a, in_b, in_tag}),
      .data_o  (headOp),
      .count_o (fifoCount)
   );

   // A capture on the same edge as a consumer accept overrides the clear.
   always_comb begin
      state_d    = state_q;
      mulA_d     = mulA_q;
      mulB_d     = mulB_q;
      tag_d      = tag_q;
      resOut_d   = resOut_q;
      resTag_d   = resTag_q;
      resValid_d = resValid_q;
      err_d      = err_q;
      wdog_d     = wdog_q;
      if (resValid_q && res_ready) begin
         resValid_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d = ISSUE;
               mulA_d  = headOp[OPW-1 -: FLOAT_WIDTH];
               mulB_d  = headOp[TAG_WIDTH +: FLOAT_WIDTH];
               tag_d   = headOp[TAG_WIDTH-1:0];
            end
         end
         ISSUE: begin
            state_d = WAIT;
            wdog_d  = '0;
         end
         WAIT: begin
            if (mul_ack) begin
               resOut_d   = mul_out;
               resTag_d   = tag_q;
               resValid_d = 1'b1;
               state_d    = IDLE;
            end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         mulA_q     <= '0;
         mulB_q     <= '0;
         tag_q      <= '0;
         resOut_q   <= '0;
         resTag_q   <= '0;
         resValid_q <= 1'b0;
         err_q      <= 1'b0;
         wdog_q     <= '0;
      end else begin
         state_q    <= state_d;
         mulA_q     <= mulA_d;
         mulB_q     <= mulB_d;
         tag_q      <= tag_d;
         resOut_q   <= resOut_d;
         resTag_q   <= resTag_d;
         resValid_q <= resValid_d;
         err_q      <= err_d;
         wdog_q     <= wdog_d;
      end
   end

   assign mul_req   = (state_q == ISSUE);
   assign mul_a     = mulA_q;
   assign mul_b     = mulB_q;
   assign res_valid = resValid_q;
   assign res_out   = resOut_q;
   assign res_tag   = resTag_q;
   assign count     = fifoCount;
   assign err       = err_q;

endmodule

// File: tb/tb_float_mul_issue_queue.sv
// Self-checking bench for float_mul_issue_queue with a behavioural
// variable-latency multiplier and a result scoreboard.
module tb_float_mul_issue_queue;
   import float_mul_issue_queue_pkg::*;

   localparam int FW = 32;
   localparam int TW = 4;
   localparam int DEPTH = 4;
   localparam int TIMEOUT = 127;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0, in_ready;
   logic [FW-1:0] in_a = '0, in_b = '0;
   logic [TW-1:0] in_tag = '0;
   logic          mul_req, mul_ack;
   logic [FW-1:0] mul_a, mul_b, mul_out;
   logic          res_valid, res_ready = 1'b0;
   logic [FW-1:0] res_out;
   logic [TW-1:0] res_tag;
   logic [2:0]    count;
   logic          err;

   logic          stubAck, strayAck = 1'b0, stubHang = 1'b0;
   int            stubCnt;
   logic [FW-1:0] stubProd;

   typedef struct {
      real          val;
      logic [TW-1:0] tag;
   } expect_t;
   expect_t sbQ[$];

   int assertions = 0;
   int failures = 0;
   int reqPulses = 0;
   int resAccepts = 0;
   logic [FW-1:0] lastResOut = '0;
   expect_t monExp;
   real monGot, monDiff, monTol;

   assign mul_ack = stubAck | strayAck;

   float_mul_issue_queue #(
      .FLOAT_WIDTH (FW),
      .DEPTH       (DEPTH),
      .TAG_WIDTH   (TW),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .mul_req   (mul_req),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_ack   (mul_ack),
      .mul_out   (mul_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_out   (res_out),
      .res_tag   (res_tag),
      .count     (count),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Single precision <-> real conversion for normal numbers and zero.
   function automatic real f2r(input logic [31:0] f);
      logic [10:0] e;
      if (f[30:0] == 31'd0) return 0.0;
      e = {3'b000, f[30:23]} + 11'd896;
      return $bitstoreal({f[31], e, f[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // Multiplier model: one-cycle latency when an operand is zero, three otherwise.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         stubAck <= 1'b0;
         stubCnt <= 0;
         mul_out <= '0;
      end else begin
         stubAck <= 1'b0;
         if (stubCnt == 1) begin
            stubAck <= 1'b1;
            mul_out <= stubProd;
         end
         if (stubCnt != 0) stubCnt <= stubCnt - 1;
         if (mul_req && !stubHang) begin
            stubCnt  <= (mul_a[30:0] == 31'd0 || mul_b[30:0] == 31'd0) ? 1 : 3;
            stubProd <= r2f(f2r(mul_a) * f2r(mul_b));
         end
      end
   end

   // Scoreboard consumer: every accepted result must match the oldest expectation.
   always @(negedge clk) begin
      if (rst) begin
         if (mul_req) reqPulses++;
         if (res_valid && res_ready) begin
            resAccepts++;
            lastResOut = res_out;
            assertions++;
            if (sbQ.size() == 0) begin
               failures++;
               $display("[TB] FAIL unexpected_result: got res_out=%h tag=%0d, required no result", res_out, res_tag);
            end else begin
               monExp  = sbQ.pop_front();
               monGot  = f2r(res_out);
               monDiff = monGot - monExp.val;
               if (monDiff < 0.0) monDiff = -monDiff;
               monTol  = ((monExp.val < 0.0) ? -monExp.val : monExp.val) * 1.0e-5 + 1.0e-6;
               if (monDiff > monTol || res_tag !== monExp.tag) begin
                  failures++;
                  $display("[TB] FAIL result: got %f tag %0d, required %f tag %0d", monGot, res_tag, monExp.val, monExp.tag);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushOp(input real a, input real b, input logic [TW-1:0] tag,
                         input bit expectRes, input real expVal);
      bit done = 1'b0;
      in_a = r2f(a);
      in_b = r2f(b);
      in_tag = tag;
      in_valid = 1'b1;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1'b1;
            if (expectRes) sbQ.push_back('{expVal, tag});
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      assertions++;
      if (!done) begin
         failures++;
         $display("[TB] FAIL push_accept: got in_ready=0 for 300 cycles, required acceptance");
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      assertions++;
      if (count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d, required 0", count); end
      assertions++;
      if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready); end
      assertions++;
      if ({mul_req, res_valid, err} !== 3'b000) begin
         failures++; $display("[TB] FAIL reset_flags: got req/valid/err=%b, required 000", {mul_req, res_valid, err});
      end
      assertions++;
      if ({mul_a, mul_b, res_out, res_tag} !== '0) begin
         failures++; $display("[TB] FAIL reset_data: got %h %h %h %h, required all 0", mul_a, mul_b, res_out, res_tag);
      end
      @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single_op();
      int p0 = reqPulses;
      int a0 = resAccepts;
      res_ready = 1'b1;
      pushOp(2.0, 3.0, 4'd5, 1'b1, 6.0);
      for (int i = 0; i < 300 && sbQ.size() != 0; i++) @(negedge clk);
      repeat (5) tick();
      assertions++;
      if (sbQ.size() != 0) begin failures++; $display("[TB] FAIL single_drain: got %0d pending, required 0", sbQ.size()); end
      assertions++;
      if (reqPulses - p0 != 1) begin failures++; $display("[TB] FAIL single_req_pulses: got %0d, required 1", reqPulses - p0); end
      assertions++;
      if (resAccepts - a0 != 1) begin failures++; $display("[TB] FAIL single_valid_cycles: got %0d, required 1", resAccepts - a0); end
      assertions++;
      if (lastResOut !== 32'h40C0_0000) begin failures++; $display("[TB] FAIL single_bits: got %h, required 40c00000", lastResOut); end
      assertions++;
      if (count !== 3'd0) begin failures++; $display("[TB] FAIL single_count: got %0d, required 0", count); end
   endtask

   task automatic test_fill();
      int p0 = reqPulses;
      bit heldBad = 1'b0;
      res_ready = 1'b0;
      for (int i = 1; i <= 5; i++) pushOp(real'(i), 2.0, 4'(i), 1'b1, 2.0 * i);
      assertions++;
      if (count !== 3'd4 || in_ready !== 1'b0) begin
         failures++; $display("[TB] FAIL fill_full: got count=%0d in_ready=%b, required 4 and 0", count, in_ready);
      end
      in_a = r2f(9.0); in_b = r2f(9.0); in_tag = 4'd7; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (count !== 3'd4 || in_ready !== 1'b0) heldBad = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      assertions++;
      if (heldBad) begin failures++; $display("[TB] FAIL fill_holdoff: got count change while full, required count=4"); end
      repeat (20) tick();
      assertions++;
      if (reqPulses - p0 != 1 || res_valid !== 1'b1) begin
         failures++; $display("[TB] FAIL fill_blocked: got %0d req pulses valid=%b, required 1 and 1", reqPulses - p0, res_valid);
      end
      res_ready = 1'b1;
      for (int i = 0; i < 300 && sbQ.size() != 0; i++) @(negedge clk);
      repeat (3) tick();
      assertions++;
      if (sbQ.size() != 0 || reqPulses - p0 != 5 || count !== 3'd0) begin
         failures++; $display("[TB] FAIL fill_drain: got pending=%0d pulses=%0d count=%0d, required 0 5 0", sbQ.size(), reqPulses - p0, count);
      end
   endtask

   task automatic test_order_sign();
      res_ready = 1'b1;
      pushOp(1.1, 1.1, 4'd1, 1'b1, 1.21);
      pushOp(-2000.0, 2.3, 4'd2, 1'b1, -4600.0);
      pushOp(-2000.0, -2.3, 4'd3, 1'b1, 4600.0);
      for (int i = 0; i < 300 && sbQ.size() != 0; i++) @(negedge clk);
      tick();
      assertions++;
      if (sbQ.size() != 0) begin failures++; $display("[TB] FAIL order_drain: got %0d pending, required 0", sbQ.size()); end
   endtask

   task automatic test_zero_fast();
      res_ready = 1'b1;
      pushOp(0.0, 1.0, 4'd11, 1'b1, 0.0);
      pushOp(11.0, 11.0, 4'd12, 1'b1, 121.0);
      for (int i = 0; i < 300 && sbQ.size() != 0; i++) @(negedge clk);
      tick();
      assertions++;
      if (sbQ.size() != 0) begin failures++; $display("[TB] FAIL zero_drain: got %0d pending, required 0", sbQ.size()); end
   endtask

   task automatic test_timeout();
      bit found = 1'b0;
      int waited = -1;
      res_ready = 1'b1;
      stubHang = 1'b1;
      pushOp(1.5, 2.0, 4'd9, 1'b0, 0.0);
      pushOp(3.0, 2.0, 4'd10, 1'b1, 6.0);
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk);
         if (mul_req) found = 1'b1;
      end
      @(posedge clk);
      for (int i = 1; i <= 300 && waited < 0; i++) begin
         @(negedge clk);
         if (err) begin
            waited = i - 1;
            stubHang = 1'b0;
         end
      end
      stubHang = 1'b0;
      assertions++;
      if (waited != TIMEOUT) begin failures++; $display("[TB] FAIL timeout_cycles: got %0d, required %0d", waited, TIMEOUT); end
      for (int i = 0; i < 300 && sbQ.size() != 0; i++) @(negedge clk);
      repeat (3) tick();
      assertions++;
      if (sbQ.size() != 0 || err !== 1'b1) begin
         failures++; $display("[TB] FAIL timeout_next_issue: got pending=%0d err=%b, required 0 and 1", sbQ.size(), err);
      end
   endtask

   task automatic test_reset_in_wait();
      int p0, a0;
      res_ready = 1'b1;
      stubHang = 1'b1;
      for (int i = 0; i < 3; i++) pushOp(5.0, 5.0, 4'(i), 1'b0, 0.0);
      repeat (3) @(posedge clk);
      assertions++;
      if (count !== 3'd2) begin failures++; $display("[TB] FAIL wait_queued: got count=%0d, required 2", count); end
      #3;
      rst = 1'b0;
      #1;
      assertions++;
      if (count !== 3'd0 || res_valid !== 1'b0 || err !== 1'b0 || mul_req !== 1'b0) begin
         failures++; $display("[TB] FAIL async_reset: got count=%0d valid=%b err=%b req=%b, required 0 0 0 0", count, res_valid, err, mul_req);
      end
      @(negedge clk);
      rst = 1'b1;
      stubHang = 1'b0;
      p0 = reqPulses;
      a0 = resAccepts;
      tick();
      strayAck = 1'b1;
      tick();
      strayAck = 1'b0;
      repeat (10) tick();
      assertions++;
      if (resAccepts != a0 || reqPulses != p0 || count !== 3'd0) begin
         failures++; $display("[TB] FAIL stray_ack: got results=%0d reqs=%0d count=%0d, required 0 0 0", resAccepts - a0, reqPulses - p0, count);
      end
   endtask

   initial begin
      $display("[TB] starting float_mul_issue_queue bench");
      test_reset();
      test_single_op();
      test_fill();
      test_order_sign();
      test_zero_fast();
      test_timeout();
      test_reset_in_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
